// File: rtl/mandel_host_link_if.sv
// Job/result link bundle between host control, UART byte engines and framebuffer write port.
// master = surrounding logic, slave = mandel_host_link.
interface mandel_host_link_if;
    logic        start;
    logic [7:0]  pix_x;
    logic [7:0]  pix_y;
    logic [15:0] cxs;
    logic [15:0] cys;
    logic [15:0] dcx;
    logic [15:0] dcy;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  t_data;
    logic        t_start;
    logic        t_busy;
    logic [7:0]  r_data;
    logic        r_ready;
    logic [7:0]  wx;
    logic [6:0]  wy;
    logic [1:0]  wd;
    logic        we;

    modport master (
        output start, pix_x, pix_y, cxs, cys, dcx, dcy, t_busy, r_data, r_ready,
        input  busy, done, err, t_data, t_start, wx, wy, wd, we
    );

    modport slave (
        input  start, pix_x, pix_y, cxs, cys, dcx, dcy, t_busy, r_data, r_ready,
        output busy, done, err, t_data, t_start, wx, wy, wd, we
    );
endinterface

// File: rtl/mandel_host_link.sv
// Mandelbrot job initiator: serialises a 10-byte job to the UART TX, paints each returned byte.
// Optional RX inactivity abort is compiled in with MANDEL_LINK_TIMEOUT_EN.
module mandel_host_link #(
    parameter int MAX_ITER    = 100,
    parameter int N_PIX_X     = 192,
    parameter int N_PIX_Y     = 128,
    parameter int TIMEOUT_CYC = 2400000
) (
    input  logic               clk,
    input  logic               rst,
    mandel_host_link_if.slave  link_io
);

    typedef enum logic [2:0] {
        IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_IDLE, RX_WAIT, RX_WRITE, RX_RELEASE, DONE
    } state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_ITER);
    localparam logic [8:0] LIM_X = 9'(N_PIX_X);
    localparam logic [8:0] LIM_Y = 9'(N_PIX_Y);

    state_t       state_q;
    logic [79:0]  job_q;
    logic [3:0]   byte_cnt_q;
    logic [7:0]   pix_x_q, pix_y_q;
    logic [7:0]   cx_q, cy_q;
    logic [7:0]   rx_byte_q;
    logic [15:0]  pix_cnt_q;
    logic         rx_prev_q;
    logic         busy_q, done_q, t_start_q, we_q;
    logic [7:0]   t_data_q, wx_q;
    logic [6:0]   wy_q;
    logic [1:0]   wd_q;

    logic [15:0]  pix_total;
    logic [1:0]   colour;
    logic         in_bounds;
    logic         unused_tmo;

    assign pix_total  = 16'(pix_x_q) * 16'(pix_y_q);
    assign in_bounds  = ({1'b0, cx_q} < LIM_X) && ({1'b0, cy_q} < LIM_Y);
    assign unused_tmo = (TIMEOUT_CYC > 0);

    always_comb begin
        colour = rx_byte_q[1:0];
        if (rx_byte_q == MAX_B)
            colour = 2'b00;
        else if (rx_byte_q[1:0] == 2'b00)
            colour = 2'b11;
    end

`ifdef MANDEL_LINK_TIMEOUT_EN
    localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
    assign link_io.err = err_q;
`else
    assign link_io.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            job_q      <= '0;
            byte_cnt_q <= '0;
            pix_x_q    <= '0;
            pix_y_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            rx_byte_q  <= '0;
            pix_cnt_q  <= '0;
            rx_prev_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            t_start_q  <= 1'b0;
            we_q       <= 1'b0;
            t_data_q   <= '0;
            wx_q       <= '0;
            wy_q       <= '0;
            wd_q       <= '0;
`ifdef MANDEL_LINK_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            // Edge flag follows r_ready in every state so bytes seen during TX are discarded.
            rx_prev_q <= link_io.r_ready;
            done_q    <= 1'b0;
            t_start_q <= 1'b0;
            we_q      <= 1'b0;
`ifdef MANDEL_LINK_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (link_io.start) begin
                        job_q      <= {link_io.pix_x, link_io.pix_y, link_io.cxs, link_io.cys,
                                       link_io.dcx, link_io.dcy};
                        pix_x_q    <= link_io.pix_x;
                        pix_y_q    <= link_io.pix_y;
                        byte_cnt_q <= '0;
                        pix_cnt_q  <= '0;
                        cx_q       <= '0;
                        cy_q       <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= (link_io.pix_x == 8'd0 || link_io.pix_y == 8'd0) ? DONE : TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    if (!link_io.t_busy) begin
                        t_data_q  <= job_q[79:72];
                        t_start_q <= 1'b1;
                        job_q     <= {job_q[71:0], 8'h00};
                        state_q   <= TX_WAIT_BUSY;
                    end
                end
                TX_WAIT_BUSY: begin
                    if (link_io.t_busy)
                        state_q <= TX_WAIT_IDLE;
                end
                TX_WAIT_IDLE: begin
                    if (!link_io.t_busy) begin
                        byte_cnt_q <= byte_cnt_q + 4'd1;
                        if (byte_cnt_q == 4'd9) begin
                            state_q <= RX_WAIT;
`ifdef MANDEL_LINK_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end else begin
                            state_q <= TX_LOAD;
                        end
                    end
                end
                RX_WAIT: begin
                    if (link_io.r_ready && !rx_prev_q) begin
                        rx_byte_q <= link_io.r_data;
                        state_q   <= RX_WRITE;
                    end
`ifdef MANDEL_LINK_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                RX_WRITE: begin
                    we_q      <= in_bounds;
                    wx_q      <= cx_q;
                    wy_q      <= cy_q[6:0];
                    wd_q      <= colour;
                    pix_cnt_q <= pix_cnt_q + 16'd1;
                    // Column-major walk: rows advance first, then the column.
                    if (cy_q == pix_y_q - 8'd1) begin
                        cy_q <= '0;
                        cx_q <= cx_q + 8'd1;
                    end else begin
                        cy_q <= cy_q + 8'd1;
                    end
                    state_q <= RX_RELEASE;
                end
                RX_RELEASE: begin
                    if (!link_io.r_ready) begin
                        if (pix_cnt_q == pix_total) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RX_WAIT;
`ifdef MANDEL_LINK_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign link_io.busy    = busy_q;
    assign link_io.done    = done_q;
    assign link_io.t_data  = t_data_q;
    assign link_io.t_start = t_start_q;
    assign link_io.wx      = wx_q;
    assign link_io.wy      = wy_q;
    assign link_io.wd      = wd_q;
    assign link_io.we      = we_q;

endmodule

// File: tb/tb_mandel_host_link.sv
// Scoreboarded bench for mandel_host_link: job byte stream, pixel writes, bounds, handshakes, timeout.
// Timeout expectations follow MANDEL_LINK_TIMEOUT_EN.
module tb_mandel_host_link;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mandel_host_link_if link();

    mandel_host_link #(
        .MAX_ITER(100), .N_PIX_X(192), .N_PIX_Y(128), .TIMEOUT_CYC(50)
    ) dut (
        .clk(clk), .rst(rst), .link_io(link)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [1:0] d;
    } wr_t;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_tx[$];
    wr_t        exp_wr[$];
    logic [7:0] res_q[$];
    int done_cnt = 0, err_cnt = 0, tstart_cnt = 0, cyc = 0, last_tstart_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] colour_of(input logic [7:0] b);
        if (b == 8'd100) return 2'b00;
        if (b % 4 == 0)  return 2'b11;
        return b[1:0];
    endfunction

    // Monitor: pops scoreboard queues whenever the DUT presents a transfer.
    always @(negedge clk) begin
        cyc++;
        if (rst === 1'b0) begin
            if (link.t_start) begin
                tstart_cnt++;
                last_tstart_cyc = cyc;
                chk("t_start_while_t_busy", 32'(link.t_busy), 32'd0);
                if (exp_tx.size() == 0) chk("unexpected_t_start_queue", 32'(exp_tx.size()), 32'd1);
                else                    chk("t_data", 32'(link.t_data), 32'(exp_tx.pop_front()));
            end
            if (link.we) begin
                if (exp_wr.size() == 0) chk("unexpected_we_queue", 32'(exp_wr.size()), 32'd1);
                else                    chk("write_x_y_d", 32'({link.wx, link.wy, link.wd}), 32'(exp_wr.pop_front()));
            end
            if (link.done) done_cnt++;
            if (link.err)  err_cnt++;
        end
    end

    // Transmitter echo: busy rises a little after each strobe and drops some cycles later.
    initial begin
        link.t_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && link.t_start) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                @(posedge clk); #1 link.t_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1 link.t_busy = 1'b0;
            end
        end
    end

    task automatic start_job(input logic [7:0] px, input logic [7:0] py, input logic [15:0] cx,
                             input logic [15:0] cy, input logic [15:0] dx, input logic [15:0] dy,
                             input bit accept);
        @(posedge clk); #1;
        link.start = 1'b1; link.pix_x = px; link.pix_y = py;
        link.cxs = cx; link.cys = cy; link.dcx = dx; link.dcy = dy;
        if (accept && px != 0 && py != 0) begin
            exp_tx.push_back(px); exp_tx.push_back(py);
            exp_tx.push_back(cx[15:8]); exp_tx.push_back(cx[7:0]);
            exp_tx.push_back(cy[15:8]); exp_tx.push_back(cy[7:0]);
            exp_tx.push_back(dx[15:8]); exp_tx.push_back(dx[7:0]);
            exp_tx.push_back(dy[15:8]); exp_tx.push_back(dy[7:0]);
        end
        @(posedge clk); #1 link.start = 1'b0;
    endtask

    task automatic wait_tx_drained(input string name);
        for (int i = 0; i < 400 && exp_tx.size() != 0; i++) @(negedge clk);
        chk(name, 32'(exp_tx.size()), 32'd0);
        repeat (12) @(posedge clk);
    endtask

    task automatic send_result(input logic [7:0] b, input int hold);
        @(posedge clk); #1;
        link.r_data = b; link.r_ready = 1'b1;
        repeat (hold) @(posedge clk);
        #1 link.r_ready = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_done(input string name, input int d0);
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clk);
        @(negedge clk);
        chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk({name, "_busy_after"}, 32'(link.busy), 32'd0);
    endtask

    // Full job: reference model builds the byte stream and the column-major write list.
    task automatic run_job(input string name, input logic [7:0] px, input logic [7:0] py,
                           input logic [15:0] cx, input logic [15:0] cy, input logic [15:0] dx,
                           input logic [15:0] dy, input int hold_hi);
        int n, d0, t0;
        n  = int'(px) * int'(py);
        d0 = done_cnt;
        t0 = tstart_cnt;
        if (res_q.size() == 0)
            for (int i = 0; i < n; i++)
                res_q.push_back(($urandom_range(0, 3) == 0) ? 8'd100 : 8'($urandom_range(0, 255)));
        for (int i = 0; i < n; i++)
            if (i / int'(py) < 192 && i % int'(py) < 128)
                exp_wr.push_back('{x: 8'(i / int'(py)), y: 7'(i % int'(py)), d: colour_of(res_q[i])});
        start_job(px, py, cx, cy, dx, dy, 1'b1);
        wait_tx_drained({name, "_tx_drain"});
        chk({name, "_t_start_count"}, 32'(tstart_cnt - t0), 32'd10);
        for (int i = 0; i < n; i++) send_result(res_q[i], $urandom_range(1, hold_hi));
        res_q.delete();
        wait_done(name, d0);
        chk({name, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        int d0, e0, t0, lat;
        rst = 1'b1;
        link.start = 1'b0; link.pix_x = '0; link.pix_y = '0;
        link.cxs = '0; link.cys = '0; link.dcx = '0; link.dcy = '0;
        link.r_data = '0; link.r_ready = 1'b0;

        // Reset with start held high
        @(posedge clk); #1;
        link.start = 1'b1; link.pix_x = 8'd2; link.pix_y = 8'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_outputs_zero", 32'({link.busy, link.done, link.err, link.t_start, link.we,
                                           link.t_data, link.wx, link.wy, link.wd}), 32'd0);
        end
        #1 link.start = 1'b0; rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_after_reset", 32'(link.busy), 32'd0);
        chk("t_start_after_reset", 32'(tstart_cnt), 32'd0);

        // Fixed 2x3 job with known results
        res_q = '{8'd100, 8'd5, 8'd4, 8'd7, 8'd100, 8'd2};
        run_job("job2x3", 8'd2, 8'd3, 16'hE000, 16'hF000, 16'h0040, 16'h0040, 3);

        // Held r_ready and a start while busy
        t0 = tstart_cnt;
        d0 = done_cnt;
        res_q = '{8'd9};
        exp_wr.push_back('{x: 8'd0, y: 7'd0, d: colour_of(8'd9)});
        start_job(8'd1, 8'd1, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 1'b1);
        repeat (3) @(posedge clk);
        start_job(8'd4, 8'd4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0);
        wait_tx_drained("held_tx_drain");
        send_result(8'd9, 10);
        res_q.delete();
        wait_done("held", d0);
        chk("held_t_start_count", 32'(tstart_cnt - t0), 32'd10);
        chk("held_writes_left", 32'(exp_wr.size()), 32'd0);

        // Width beyond the framebuffer
        run_job("wide200", 8'd200, 8'd1, 16'h0100, 16'h0200, 16'h0010, 16'h0020, 2);

        // Random small jobs
        for (int j = 0; j < 3; j++)
            run_job("rand", 8'($urandom_range(1, 5)), 8'($urandom_range(1, 5)), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 4);

        // Zero-size job
        t0 = tstart_cnt;
        d0 = done_cnt;
        start_job(8'd0, 8'd3, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        wait_done("zero", d0);
        chk("zero_t_start_count", 32'(tstart_cnt - t0), 32'd0);

        // No result bytes
        d0 = done_cnt;
        e0 = err_cnt;
        start_job(8'd1, 8'd1, 16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, 1'b1);
        wait_tx_drained("tmo_tx_drain");
`ifdef MANDEL_LINK_TIMEOUT_EN
        for (int i = 0; i < 100 && err_cnt == e0; i++) @(negedge clk);
        lat = cyc - last_tstart_cyc;
        chk("tmo_err_pulses", 32'(err_cnt - e0), 32'd1);
        chk("tmo_err_latency_50_to_65", 32'(lat >= 50 && lat <= 65), 32'd1);
        repeat (3) @(negedge clk);
        chk("tmo_err_once", 32'(err_cnt - e0), 32'd1);
        chk("tmo_busy", 32'(link.busy), 32'd0);
        chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
        run_job("after_tmo", 8'd1, 8'd2, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 2);
`else
        repeat (100) @(negedge clk);
        lat = cyc - last_tstart_cyc;
        chk("no_tmo_err", 32'(err_cnt - e0), 32'd0);
        chk("no_tmo_busy_held", 32'(link.busy), 32'd1);
        chk("no_tmo_waited", 32'(lat >= 100), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_wr.delete();
        repeat (3) @(negedge clk);
        chk("abort_busy", 32'(link.busy), 32'd0);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("final_tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
